// File: rtl/pio_arb_pkg.sv
// Shared types and helpers for the PIO read arbiter.
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  localparam int DEF_NUM_REQ = 2;
  localparam int DEF_ADDR_W  = 2;
  localparam int DEF_DATA_W  = 32;
  localparam int MAX_REQ     = 8;

  // Bit idx set when idx is a valid master index below n, otherwise all zero.
  function automatic logic [MAX_REQ-1:0] onehot(input int idx, input int n);
    if (idx >= 0 && idx < n) begin
      onehot = MAX_REQ'(1) << idx;
    end else begin
      onehot = '0;
    end
  endfunction

endpackage

// File: rtl/pio_read_arbiter_rr_arbiter.sv
// Combinational winner selection among pending read requests.
// PIO_ARB_FIXED_PRIO_EN switches from round-robin to lowest-index-wins.
module rr_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [$clog2(NUM_REQ)-1:0] winner,
  output logic                       any_req
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic found;

`ifdef PIO_ARB_FIXED_PRIO_EN
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    any_req = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end
`else
  // First pass covers indices above last_grant, second pass wraps to the bottom.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    any_req = |req;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && i > int'(last_grant)) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        winner = IDX_W'(i);
        found  = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/pio_read_arbiter.sv
// Shares one registered-readback PIO slave among NUM_REQ read-only masters.
// Optional build macro PIO_ARB_FIXED_PRIO_EN selects fixed priority arbitration.
module pio_read_arbiter
  import pio_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic [ADDR_W-1:0]         pio_address,
  output logic                      pio_read,
  input  logic [DATA_W-1:0]         pio_readdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t             state;
  state_t             state_next;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   winner;
  logic               any_req;
  logic [NUM_REQ-1:0] winner_oh;
  logic [NUM_REQ-1:0] grant_oh;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req       (req_read),
    .last_grant(last_grant),
    .winner    (winner),
    .any_req   (any_req)
  );

  assign winner_oh = NUM_REQ'(onehot(int'(winner), NUM_REQ));
  assign grant_oh  = NUM_REQ'(onehot(int'(grant), NUM_REQ));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Only the winner is released in IDLE; with no request pending everyone is.
  always_comb begin
    state_next      = state;
    req_waitrequest = '1;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_next      = ADDR;
          req_waitrequest = ~winner_oh;
        end else begin
          req_waitrequest = '0;
        end
      end
      ADDR:    state_next = DATA;
      DATA:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_address       <= '0;
      pio_read          <= 1'b0;
      req_readdata      <= '0;
      req_readdatavalid <= '0;
      grant             <= '0;
      last_grant        <= IDX_W'(NUM_REQ - 1);
    end else begin
      req_readdatavalid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            pio_address <= req_address[winner*ADDR_W +: ADDR_W];
            grant       <= winner;
            last_grant  <= winner;
            pio_read    <= 1'b1;
          end
        end
        DATA: begin
          req_readdata      <= pio_readdata;
          req_readdatavalid <= grant_oh;
          pio_read          <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
